lexer_sequencer: RTL and testbench

LEXER_SEQUENCER -- requirements
Module: lexer_sequencer

---
 rtl/lexer_pkg.sv | 43 ++++
 rtl/lexer_sequencer_line_buffer.sv | 42 ++++
 rtl/lexer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_lexer_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lexer_pkg.sv
// Shared key codes, lexer token values and sequencer FSM encoding for the lexer front end.
package lexer_pkg;

  localparam int unsigned LINE_MAX = 32;

  // Character codes: lowercase a..z = 1..26, uppercase A..Z = 27..52, then punctuation.
  localparam logic [7:0] CODE_A_LO    = 8'd1;
  localparam logic [7:0] CODE_Z_LO    = 8'd26;
  localparam logic [7:0] CODE_A_UP    = 8'd27;
  localparam logic [7:0] CODE_Z_UP    = 8'd52;
  localparam logic [7:0] CODE_DOLLAR  = 8'd53;
  localparam logic [7:0] CODE_LBRACE  = 8'd54;
  localparam logic [7:0] CODE_RBRACE  = 8'd55;
  localparam logic [7:0] CODE_EQ      = 8'd56;
  localparam logic [7:0] CODE_LAMBDA  = 8'd57;
  localparam logic [7:0] CODE_DOT     = 8'd58;
  localparam logic [7:0] CODE_LPAREN  = 8'd59;
  localparam logic [7:0] CODE_RPAREN  = 8'd60;
  localparam logic [7:0] CODE_END     = 8'd61;
  localparam logic [7:0] CODE_BKSP    = 8'd65;
  localparam logic [7:0] CODE_ENTER   = 8'd66;
  localparam logic [7:0] CODE_UP      = 8'd67;
  localparam logic [7:0] CODE_DOWN    = 8'd68;

  localparam logic [7:0] CODE_CHAR_MIN = CODE_A_LO;
  localparam logic [7:0] CODE_CHAR_MAX = CODE_RPAREN;

  // Values presented on lex_data
  localparam logic [7:0] TOK_NONE = 8'd0;
  localparam logic [7:0] TOK_END  = CODE_END;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2,
    ST_TERM  = 2'd3
  } lex_state_t;

  function automatic logic is_char_code(input logic [7:0] code);
    return (code >= CODE_CHAR_MIN) && (code <= CODE_CHAR_MAX);
  endfunction

endpackage

// File: rtl/lexer_sequencer_line_buffer.sv
// 32x6 edit-line register file: one synchronous write port, one asynchronous read port.
// With LEXER_SEQUENCER_HISTORY_EN defined it also has a whole-line load and snapshot port.
module line_buffer
  import lexer_pkg::*;
(
  input  logic                  clk_25mhz,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [5:0]            wdata,
  input  logic [4:0]            raddr,
  output logic [5:0]            rdata
`ifdef LEXER_SEQUENCER_HISTORY_EN
  ,
  input  logic                  load_en,
  input  logic [LINE_MAX-1:0][5:0] load_data,
  output logic [LINE_MAX-1:0][5:0] dump_data
`endif
);

  logic [LINE_MAX-1:0][5:0] mem;

`ifdef LEXER_SEQUENCER_HISTORY_EN
  always_ff @(posedge clk_25mhz) begin
    if (load_en) begin
      mem <= load_data;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign dump_data = mem;
`else
  always_ff @(posedge clk_25mhz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  assign rdata = mem[raddr];

endmodule

// File: rtl/lexer_sequencer.sv
// Line editor and lexer feed sequencer: collects key codes into a line, then streams it to the lexer.
// Optional line history is enabled by defining LEXER_SEQUENCER_HISTORY_EN.
module lexer_sequencer
  import lexer_pkg::*;
(
  input  logic       clk_25mhz,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       step_req,
  input  logic [7:0] step_val,
  output logic       step_ack,
  output logic       lex_reset,
  output logic       lex_io,
  output logic [7:0] lex_data,
  output logic [7:0] lex_step,
  output logic [5:0] line_len,
  output logic       busy,
  output logic       overflow
);

  lex_state_t state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [5:0] len_q, len_d;
  logic       ovf_q, ovf_d;

  logic       step_ack_d, lex_reset_d, lex_io_d;
  logic [7:0] lex_data_d, lex_step_d;

  logic       buf_we;
  logic [5:0] buf_rdata;
  logic       grant;

`ifdef LEXER_SEQUENCER_HISTORY_EN
  logic [LINE_MAX-1:0][5:0] hist_q;
  logic [LINE_MAX-1:0][5:0] line_snapshot;
  logic [5:0]               hist_len_q;
  logic                     hist_we;
  logic                     hist_load;
`endif

  line_buffer u_line_buffer (
    .clk_25mhz (clk_25mhz),
    .we        (buf_we),
    .waddr     (len_q[4:0]),
    .wdata     (key_code[5:0]),
    .raddr     (idx_q),
    .rdata     (buf_rdata)
`ifdef LEXER_SEQUENCER_HISTORY_EN
    ,
    .load_en   (hist_load),
    .load_data (hist_q),
    .dump_data (line_snapshot)
`endif
  );

  assign grant = step_req && (state_q != ST_CLEAR);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    buf_we      = 1'b0;
    step_ack_d  = 1'b0;
    lex_reset_d = 1'b0;
    lex_io_d    = 1'b0;
    lex_data_d  = TOK_NONE;
    lex_step_d  = 8'd0;
`ifdef LEXER_SEQUENCER_HISTORY_EN
    hist_we     = 1'b0;
    hist_load   = 1'b0;
`endif

    if (grant) begin
      step_ack_d = 1'b1;
      lex_io_d   = 1'b1;
      lex_step_d = step_val;
    end

    case (state_q)
      // Line editing in IDLE runs independently of step grants; only FEED/TERM stall.
      ST_IDLE: begin
        if (key_valid) begin
          if (is_char_code(key_code)) begin
            if (len_q < 6'(LINE_MAX)) begin
              buf_we = 1'b1;
              len_d  = len_q + 6'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (key_code == CODE_BKSP) begin
            if (len_q != 6'd0) begin
              len_d = len_q - 6'd1;
            end
          end else if (key_code == CODE_ENTER) begin
            state_d = ST_CLEAR;
`ifdef LEXER_SEQUENCER_HISTORY_EN
            hist_we = 1'b1;
          end else if (key_code == CODE_UP) begin
            hist_load = 1'b1;
            len_d     = hist_len_q;
          end else if (key_code == CODE_DOWN) begin
            len_d = 6'd0;
`endif
          end
        end
      end

      ST_CLEAR: begin
        lex_reset_d = 1'b1;
        idx_d       = 5'd0;
        state_d     = (len_q == 6'd0) ? ST_TERM : ST_FEED;
      end

      ST_FEED: begin
        if (!grant) begin
          lex_data_d = {2'b00, buf_rdata};
          if ({1'b0, idx_q} == len_q - 6'd1) begin
            state_d = ST_TERM;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end

      ST_TERM: begin
        if (!grant) begin
          lex_data_d = TOK_END;
          len_d      = 6'd0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      step_ack  <= 1'b0;
      lex_reset <= 1'b0;
      lex_io    <= 1'b0;
      lex_data  <= '0;
      lex_step  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      step_ack  <= step_ack_d;
      lex_reset <= lex_reset_d;
      lex_io    <= lex_io_d;
      lex_data  <= lex_data_d;
      lex_step  <= lex_step_d;
    end
  end

`ifdef LEXER_SEQUENCER_HISTORY_EN
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      hist_len_q <= '0;
    end else if (hist_we) begin
      hist_len_q <= len_q;
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (hist_we) begin
      hist_q <= line_snapshot;
    end
  end
`endif

  assign line_len = len_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lexer_sequencer.sv
// Directed self-checking bench for lexer_sequencer.
module tb_lexer_sequencer;

  logic       clk_25mhz = 1'b0;
  logic       reset_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       step_req;
  logic [7:0] step_val;
  logic       step_ack;
  logic       lex_reset;
  logic       lex_io;
  logic [7:0] lex_data;
  logic [7:0] lex_step;
  logic [5:0] line_len;
  logic       busy;
  logic       overflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  lexer_sequencer dut (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .step_req  (step_req),
    .step_val  (step_val),
    .step_ack  (step_ack),
    .lex_reset (lex_reset),
    .lex_io    (lex_io),
    .lex_data  (lex_data),
    .lex_step  (lex_step),
    .line_len  (line_len),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    key_code  = 8'd0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_reset"}, 32'(lex_reset), 32'd0);
    chk({tag, "_io"},    32'(lex_io),    32'd0);
    chk({tag, "_ack"},   32'(step_ack),  32'd0);
    chk({tag, "_step"},  32'(lex_step),  32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'd0;
    step_req  = 1'b0;
    step_val  = 8'd0;
    #5;
    chk("rst_lex_reset", 32'(lex_reset), 32'd0);
    chk("rst_lex_io",    32'(lex_io),    32'd0);
    chk("rst_lex_data",  32'(lex_data),  32'd0);
    chk("rst_lex_step",  32'(lex_step),  32'd0);
    chk("rst_step_ack",  32'(step_ack),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_line_len",  32'(line_len),  32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    @(negedge clk_25mhz);
    reset_n = 1'b1;
    tick();

    // Basic submit: 1,2,3 then enter
    key(8'd1); chk("a_len1", 32'(line_len), 32'd1);
    key(8'd2);
    key(8'd3); chk("a_len3", 32'(line_len), 32'd3);
    key(8'd61); chk("a_end_ignored", 32'(line_len), 32'd3);
    key(8'd70); chk("a_unknown_ignored", 32'(line_len), 32'd3);
    key(8'd66);
    chk("a_clear_busy", 32'(busy), 32'd1);
    chk("a_clear_noreset", 32'(lex_reset), 32'd0);
    tick();
    chk("a_lex_reset", 32'(lex_reset), 32'd1);
    chk("a_reset_data", 32'(lex_data), 32'd0);
    tick(); chk("a_d0", 32'(lex_data), 32'd1); chk("a_d0_rst_low", 32'(lex_reset), 32'd0);
    tick(); chk("a_d1", 32'(lex_data), 32'd2);
    tick(); chk("a_d2", 32'(lex_data), 32'd3); chk("a_term_busy", 32'(busy), 32'd1);
    tick(); chk("a_d3", 32'(lex_data), 32'd61);
    chk("a_idle_busy", 32'(busy), 32'd0);
    chk("a_len_after", 32'(line_len), 32'd0);
    tick(); chk("a_data_idle", 32'(lex_data), 32'd0);

    // Step grant stalls the feed for one cycle
    key(8'd1); key(8'd2); key(8'd66);
    tick();
    chk("c_lex_reset", 32'(lex_reset), 32'd1);
    step_req = 1'b1; step_val = 8'd2;
    tick();
    step_req = 1'b0; step_val = 8'd0;
    chk("c_io", 32'(lex_io), 32'd1);
    chk("c_step", 32'(lex_step), 32'd2);
    chk("c_ack", 32'(step_ack), 32'd1);
    chk("c_data_stall", 32'(lex_data), 32'd0);
    tick(); chk("c_d0", 32'(lex_data), 32'd1); chk_quiet("c_d0");
    tick(); chk("c_d1", 32'(lex_data), 32'd2);
    tick(); chk("c_d2", 32'(lex_data), 32'd61); chk("c_busy", 32'(busy), 32'd0);

    // Back-to-back grants in IDLE, values passed unmodified
    step_req = 1'b1; step_val = 8'd200;
    tick(); chk("bb_step0", 32'(lex_step), 32'd200); chk("bb_ack0", 32'(step_ack), 32'd1);
    step_val = 8'd255;
    tick(); chk("bb_step1", 32'(lex_step), 32'd255); chk("bb_ack1", 32'(step_ack), 32'd1);
    step_req = 1'b0; step_val = 8'd0;
    tick(); chk_quiet("bb_end");

    // Key during FEED is dropped
    key(8'd3); key(8'd66);
    tick();
    key_valid = 1'b1; key_code = 8'd7;
    tick(); chk("d_d0", 32'(lex_data), 32'd3);
    tick(); chk("d_d1", 32'(lex_data), 32'd61);
    key_valid = 1'b0; key_code = 8'd0;
    chk("d_len", 32'(line_len), 32'd0);
    chk("d_ovf", 32'(overflow), 32'd0);

    // Overflow on 33rd character, backspace floor at 0
    for (int i = 0; i < 32; i++) key(8'd5);
    chk("b_len32", 32'(line_len), 32'd32);
    chk("b_ovf0", 32'(overflow), 32'd0);
    key(8'd5);
    chk("b_len_sat", 32'(line_len), 32'd32);
    chk("b_ovf1", 32'(overflow), 32'd1);
    key(8'd65); chk("b_bksp31", 32'(line_len), 32'd31);
    for (int i = 0; i < 31; i++) key(8'd65);
    chk("b_len0", 32'(line_len), 32'd0);
    key(8'd65); chk("b_bksp_floor", 32'(line_len), 32'd0);
    chk("b_ovf_sticky", 32'(overflow), 32'd1);

    // History recall
    key(8'd4); key(8'd5); key(8'd66);
    tick(); tick(); tick(); tick();
    chk("h_first_end", 32'(lex_data), 32'd61);
    key(8'd67);
`ifdef LEXER_SEQUENCER_HISTORY_EN
    chk("h_up_len", 32'(line_len), 32'd2);
    key(8'd66);
    tick(); chk("h_reset", 32'(lex_reset), 32'd1);
    tick(); chk("h_d0", 32'(lex_data), 32'd4);
    tick(); chk("h_d1", 32'(lex_data), 32'd5);
    tick(); chk("h_d2", 32'(lex_data), 32'd61);
    key(8'd67); chk("h_up_again", 32'(line_len), 32'd2);
    key(8'd68); chk("h_down", 32'(line_len), 32'd0);
`else
    chk("h_up_ignored", 32'(line_len), 32'd0);
    key(8'd68); chk("h_down_ignored", 32'(line_len), 32'd0);
`endif

    // Reset in the middle of a feed
    key(8'd9); key(8'd9); key(8'd9); key(8'd66);
    tick(); tick();
    chk("r_mid_data", 32'(lex_data), 32'd9);
    #5;
    reset_n = 1'b0;
    #1;
    chk("r_data0", 32'(lex_data), 32'd0);
    chk("r_busy0", 32'(busy), 32'd0);
    chk("r_len0", 32'(line_len), 32'd0);
    chk("r_ovf0", 32'(overflow), 32'd0);
    chk_quiet("r_out");
    @(negedge clk_25mhz);
    reset_n = 1'b1;
    tick();
    chk("r_idle", 32'(busy), 32'd0);
    key(8'd66);
    tick(); chk("r_lex_reset", 32'(lex_reset), 32'd1); chk("r_reset_data", 32'(lex_data), 32'd0);
    tick(); chk("r_end_only", 32'(lex_data), 32'd61); chk("r_busy_end", 32'(busy), 32'd0);
`ifdef LEXER_SEQUENCER_HISTORY_EN
    key(8'd67); chk("r_hist_cleared", 32'(line_len), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
